mda_adc_poller: RTL and testbench

- Avalon-MM master that drives the depth-sensor ADC slave register interface autonomously.
- Per sample it writes the channel and start bit, polls the done flag, reads the 12-bit result and emits a tagged sample pulse.
- Replaces software polling so downstream FPGA logic receives a periodic, channel-rotated sample stream.

---
 rtl/mda_adc_pkg.sv | 31 +++
 rtl/mda_next_channel.sv | 27 ++
 rtl/mda_adc_poller.sv | 224 ++++++++++++++++++++++
 tb/tb_mda_adc_poller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mda_adc_pkg.sv
// Shared definitions for the depth-sensor ADC register interface and its poller.
package mda_adc_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned DATA_W = 12;

  // Slave register map: address 0 is start/channel on write and done on read.
  localparam logic ADDR_START_CH = 1'b0;
  localparam logic ADDR_DONE     = 1'b0;
  localparam logic ADDR_DATA     = 1'b1;

  localparam int unsigned DONE_BIT = 0;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WR_CLR   = 3'd1;
  localparam state_t ST_WR_START = 3'd2;
  localparam state_t ST_HOLDOFF  = 3'd3;
  localparam state_t ST_POLL     = 3'd4;
  localparam state_t ST_SETTLE   = 3'd5;
  localparam state_t ST_DATA_RD  = 3'd6;
  localparam state_t ST_INTERVAL = 3'd7;

  // Control word written to ADDR_START_CH.
  function automatic logic [15:0] ctrl_word(input logic [CH_W-1:0] ch, input logic start);
    return {12'b0, ch, start};
  endfunction

endpackage

// File: rtl/mda_next_channel.sv
// Round-robin channel picker: first set mask bit strictly after cur_ch, modulo 8.
module mda_next_channel
  import mda_adc_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  output logic [CH_W-1:0]   next_ch,
  output logic              found
);

  logic [CH_W-1:0] idx;

  // Offsets 1..8 from cur_ch; offset 8 wraps onto cur_ch so a lone bit reselects itself.
  always_comb begin
    next_ch = cur_ch;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = cur_ch + CH_W'(i);
      if (!found && mask[idx]) begin
        found   = 1'b1;
        next_ch = idx;
      end
    end
  end

endmodule

// File: rtl/mda_adc_poller.sv
// Avalon-MM master that starts ADC conversions, polls done and emits tagged samples.
module mda_adc_poller #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned HOLDOFF      = 8,
  parameter int unsigned SETTLE       = 4,
  parameter int unsigned POLL_TIMEOUT = 4095
) (
  input  logic        master_clk,
  input  logic        master_reset_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  input  logic [15:0] interval,
  output logic        master_chipselect_n,
  output logic        master_addr,
  output logic        master_read_n,
  output logic        master_write_n,
  output logic [15:0] master_writedata,
  input  logic [15:0] master_readdata,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        timeout_err,
  output logic        busy
);
  import mda_adc_pkg::*;

  localparam int unsigned TMO_CLOG = $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned TMO_W    = (TMO_CLOG > 12) ? TMO_CLOG : 12;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(POLL_TIMEOUT);

  localparam int unsigned CNT_A   = (HOLDOFF > SETTLE) ? HOLDOFF : SETTLE;
  localparam int unsigned CNT_MAX = (CNT_A > READ_LATENCY) ? CNT_A : READ_LATENCY;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD     = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [15:0]       ivl_q, ivl_d;
  logic              cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic              addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              valid_q, valid_d, tmo_err_q, tmo_err_d;
  logic [DATA_W-1:0] sdata_q, sdata_d;
  logic [CH_W-1:0]   sch_q, sch_d;
  logic              enter_ivl;
  logic [CH_W-1:0]   nxt_ch;
  logic              nxt_found;
  logic              unused_readdata;

  assign unused_readdata = ^master_readdata[15:DATA_W];

  mda_next_channel u_next_channel (
    .mask    (ch_mask),
    .cur_ch  (ch_q),
    .next_ch (nxt_ch),
    .found   (nxt_found)
  );

  // Sequencer: a read holds strobes while rd_n_q is low, then uses one capture cycle.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    ivl_d     = ivl_q;
    cs_n_d    = cs_n_q;
    rd_n_d    = rd_n_q;
    wr_n_d    = wr_n_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sdata_d   = sdata_q;
    sch_d     = sch_q;
    valid_d   = 1'b0;
    tmo_err_d = 1'b0;
    enter_ivl = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && nxt_found) begin
          ch_d    = nxt_ch;
          cs_n_d  = 1'b0;
          wr_n_d  = 1'b0;
          addr_d  = ADDR_START_CH;
          wdata_d = ctrl_word(nxt_ch, 1'b0);
          state_d = ST_WR_CLR;
        end
      end
      ST_WR_CLR: begin
        // Start bit low first so the following write is always a fresh rising edge.
        wdata_d = ctrl_word(ch_q, 1'b1);
        state_d = ST_WR_START;
      end
      ST_WR_START: begin
        cs_n_d  = 1'b1;
        wr_n_d  = 1'b1;
        cnt_d   = HOLD_LOAD;
        state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (cnt_q == '0) begin
          tmo_d   = '0;
          cs_n_d  = 1'b0;
          rd_n_d  = 1'b0;
          addr_d  = ADDR_DONE;
          cnt_d   = RD_LOAD;
          state_d = ST_POLL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_POLL: begin
        if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
        if (!rd_n_q) begin
          if (cnt_q == '0) begin
            cs_n_d = 1'b1;
            rd_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else if (master_readdata[DONE_BIT]) begin
          cnt_d   = SETTLE_LOAD;
          state_d = ST_SETTLE;
        end else if (tmo_q >= TMO_LIMIT) begin
          tmo_err_d = 1'b1;
          enter_ivl = 1'b1;
        end else begin
          cs_n_d = 1'b0;
          rd_n_d = 1'b0;
          cnt_d  = RD_LOAD;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b0;
          rd_n_d  = 1'b0;
          addr_d  = ADDR_DATA;
          cnt_d   = RD_LOAD;
          state_d = ST_DATA_RD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA_RD: begin
        if (!rd_n_q) begin
          if (cnt_q == '0) begin
            cs_n_d = 1'b1;
            rd_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else begin
          sdata_d   = master_readdata[DATA_W-1:0];
          sch_d     = ch_q;
          valid_d   = 1'b1;
          enter_ivl = 1'b1;
        end
      end
      ST_INTERVAL: begin
        if (ivl_q == '0) state_d = ST_IDLE;
        else             ivl_d   = ivl_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    // interval is sampled here only; zero skips the INTERVAL state entirely.
    if (enter_ivl) begin
      if (interval == '0) begin
        state_d = ST_IDLE;
      end else begin
        ivl_d   = interval - 16'd1;
        state_d = ST_INTERVAL;
      end
    end
  end

  // State and registered outputs; reset drops all strobes immediately.
  always_ff @(posedge master_clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= 3'd7;
      cnt_q     <= '0;
      tmo_q     <= '0;
      ivl_q     <= '0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      addr_q    <= 1'b0;
      wdata_q   <= '0;
      valid_q   <= 1'b0;
      sdata_q   <= '0;
      sch_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      ivl_q     <= ivl_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      valid_q   <= valid_d;
      sdata_q   <= sdata_d;
      sch_q     <= sch_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign master_chipselect_n = cs_n_q;
  assign master_read_n       = rd_n_q;
  assign master_write_n      = wr_n_q;
  assign master_addr         = addr_q;
  assign master_writedata    = wdata_q;
  assign sample_valid        = valid_q;
  assign sample_data         = sdata_q;
  assign sample_ch           = sch_q;
  assign timeout_err         = tmo_err_q;
  assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mda_adc_poller.sv
// Bench for mda_adc_poller with a behavioural ADC slave and a bus monitor.
module tb_mda_adc_poller;

  localparam int unsigned RL  = 2;
  localparam int unsigned TMO = 50;

  logic        master_clk = 1'b0;
  logic        master_reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic [15:0] interval = 16'd0;
  logic        master_chipselect_n, master_addr, master_read_n, master_write_n;
  logic [15:0] master_writedata, master_readdata;
  logic        sample_valid, timeout_err, busy;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 master_clk = ~master_clk;

  mda_adc_poller #(
    .READ_LATENCY (RL),
    .HOLDOFF      (8),
    .SETTLE       (4),
    .POLL_TIMEOUT (TMO)
  ) dut (
    .master_clk          (master_clk),
    .master_reset_n      (master_reset_n),
    .enable              (enable),
    .ch_mask             (ch_mask),
    .interval            (interval),
    .master_chipselect_n (master_chipselect_n),
    .master_addr         (master_addr),
    .master_read_n       (master_read_n),
    .master_write_n      (master_write_n),
    .master_writedata    (master_writedata),
    .master_readdata     (master_readdata),
    .sample_valid        (sample_valid),
    .sample_data         (sample_data),
    .sample_ch           (sample_ch),
    .timeout_err         (timeout_err),
    .busy                (busy)
  );

  function automatic logic [11:0] conv_val(input logic [2:0] c);
    return 12'hABC ^ {c, c, c, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ADC slave: done rises 20 cycles after a start edge unless never_done is set.
  logic        never_done = 1'b0;
  logic        slv_done = 1'b0;
  logic        slv_prev = 1'b0;
  logic [4:0]  slv_cnt = 5'd0;
  logic [2:0]  slv_ch = 3'd0;
  logic [11:0] slv_data = 12'h000;

  always @(posedge master_clk) begin
    if (!master_chipselect_n && !master_write_n && master_addr == 1'b0) begin
      slv_prev <= master_writedata[0];
      if (master_writedata[0] && !slv_prev) begin
        slv_done <= 1'b0;
        slv_cnt  <= never_done ? 5'd0 : 5'd20;
        slv_ch   <= master_writedata[3:1];
      end
    end else if (slv_cnt != 5'd0) begin
      slv_cnt <= slv_cnt - 5'd1;
      if (slv_cnt == 5'd1) begin
        slv_done <= 1'b1;
        slv_data <= conv_val(slv_ch);
      end
    end
  end

  assign master_readdata = master_addr ? {4'h0, slv_data} : {15'h0, slv_done};

  // Bus monitor: logs writes, counts bus cycles and checks read strobe length.
  logic [16:0] wq[$];
  int bus_acts = 0;
  int rd_len = 0;

  initial forever begin
    @(negedge master_clk);
    if (!master_reset_n) begin
      rd_len = 0;
    end else begin
      if (!master_chipselect_n) bus_acts++;
      if (!master_chipselect_n && !master_write_n) wq.push_back({master_addr, master_writedata});
      if (!master_read_n) begin
        rd_len++;
      end else if (rd_len != 0) begin
        check("read_len", rd_len, RL);
        rd_len = 0;
      end
    end
  end

  task automatic wait_valid(input int budget, output bit seen, output int n);
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge master_clk);
      n++;
      if (sample_valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  mask;
    logic [2:0]  ch;
    logic [15:0] wd_clr;
    logic [15:0] wd_start;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit seen;
    int n, t0, t1, nvalid, ndata, acts0, busy_cnt;

    vecs[0] = '{8'h01, 3'd0, 16'h0000, 16'h0001};
    vecs[1] = '{8'h01, 3'd0, 16'h0000, 16'h0001};
    vecs[2] = '{8'h22, 3'd1, 16'h0002, 16'h0003};
    vecs[3] = '{8'h22, 3'd5, 16'h000A, 16'h000B};
    vecs[4] = '{8'h22, 3'd1, 16'h0002, 16'h0003};
    vecs[5] = '{8'h22, 3'd5, 16'h000A, 16'h000B};
    vecs[6] = '{8'h81, 3'd7, 16'h000E, 16'h000F};
    vecs[7] = '{8'h81, 3'd0, 16'h0000, 16'h0001};
    vecs[8] = '{8'hFF, 3'd1, 16'h0002, 16'h0003};

    // Reset values
    repeat (3) @(negedge master_clk);
    check("rst_cs_n", master_chipselect_n, 1);
    check("rst_read_n", master_read_n, 1);
    check("rst_write_n", master_write_n, 1);
    check("rst_addr", master_addr, 0);
    check("rst_wdata", master_writedata, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_busy", busy, 0);
    check("rst_sdata", sample_data, 0);
    check("rst_sch", sample_ch, 0);

    ch_mask = vecs[0].mask;
    enable = 1'b1;
    master_reset_n = 1'b1;

    // Channel rotation table
    for (int i = 0; i < 9; i++) begin
      wait_valid(200, seen, n);
      check("vec_seen", seen, 1);
      if (i < 8) ch_mask = vecs[i + 1].mask;
      check("vec_ch", sample_ch, vecs[i].ch);
      check("vec_data", sample_data, conv_val(vecs[i].ch));
      check("vec_nwr", wq.size(), 2);
      if (wq.size() == 2) begin
        check("vec_wr_clr", wq[0], {1'b0, vecs[i].wd_clr});
        check("vec_wr_start", wq[1], {1'b0, vecs[i].wd_start});
      end
      wq.delete();
      @(negedge master_clk);
      check("vec_pulse", sample_valid, 0);
    end

    // Timeout: channel 2 conversion never completes
    never_done = 1'b1;
    t0 = -1; t1 = -1; nvalid = 0; ndata = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge master_clk);
      if (!master_write_n && master_writedata[0]) t0 = c;
      if (sample_valid) nvalid++;
      if (!master_read_n && master_addr) ndata++;
      if (timeout_err) begin
        t1 = c;
        break;
      end
    end
    never_done = 1'b0;
    check("tmo_seen", (t1 >= 0), 1);
    check("tmo_delay", t1 - t0, 60);
    check("tmo_no_valid", nvalid, 0);
    check("tmo_no_data_rd", ndata, 0);
    @(negedge master_clk);
    check("tmo_pulse", timeout_err, 0);
    wait_valid(200, seen, n);
    check("tmo_next_seen", seen, 1);
    check("tmo_next_ch", sample_ch, 3);

    // Interval 100: constant period between samples
    interval = 16'd100;
    wait_valid(300, seen, n);
    check("ivl_first_seen", seen, 1);
    for (int k = 0; k < 4; k++) begin
      wait_valid(300, seen, n);
      check("ivl_period", n, 133);
    end

    // Enable dropped during POLL
    interval = 16'd0;
    ch_mask = 8'h01;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge master_clk);
      if (!master_read_n && master_addr == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("dis_poll_seen", seen, 1);
    enable = 1'b0;
    wait_valid(200, seen, n);
    check("dis_valid_seen", seen, 1);
    check("dis_ch", sample_ch, 0);
    check("dis_busy", busy, 0);
    acts0 = bus_acts;
    busy_cnt = 0;
    repeat (200) begin
      @(negedge master_clk);
      if (busy) busy_cnt++;
    end
    check("dis_bus_idle", bus_acts - acts0, 0);
    check("dis_busy_idle", busy_cnt, 0);

    // Empty mask with enable high
    enable = 1'b1;
    ch_mask = 8'h00;
    acts0 = bus_acts;
    busy_cnt = 0;
    repeat (1000) begin
      @(negedge master_clk);
      if (busy) busy_cnt++;
    end
    check("nomask_bus_idle", bus_acts - acts0, 0);
    check("nomask_busy", busy_cnt, 0);

    // Reset during the data read
    ch_mask = 8'h06;
    seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge master_clk);
      if (!master_read_n && master_addr) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_rd_seen", seen, 1);
    #2 master_reset_n = 1'b0;
    #1;
    check("rst_mid_read_n", master_read_n, 1);
    check("rst_mid_cs_n", master_chipselect_n, 1);
    check("rst_mid_busy", busy, 0);
    repeat (2) @(negedge master_clk);
    wq.delete();
    master_reset_n = 1'b1;
    for (int c = 0; c < 100 && wq.size() < 2; c++) @(negedge master_clk);
    check("rst_nwr", (wq.size() >= 2), 1);
    if (wq.size() >= 2) begin
      check("rst_wr_clr", wq[0], {1'b0, 16'h0002});
      check("rst_wr_start", wq[1], {1'b0, 16'h0003});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
